// File: rtl/fu_rnd_inc_pipe.sv
// Two-stage carry-select ULP incrementer for the FPU rounder (bit 0 = MSB), valid/ready both sides.
// Stage 1 registers per-segment {x, x+ulp, all-ones}; stage 2 resolves the segment carry chain.
module fu_rnd_inc_pipe #(
  parameter int WIDTH  = 53,
  parameter int SEG    = 8,
  parameter int SP_ULP = 23
) (
  input  logic             nclk,
  input  logic             rst_b,
  input  logic             flush,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [0:WIDTH-1] x,
  input  logic             inc,
  input  logic             mode,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [0:WIDTH-1] res,
  output logic             co
);
  localparam int NSEG = (WIDTH + SEG - 1) / SEG;
  // Numeric (LSB = 0) position of the single-precision ULP.
  localparam int UP1  = WIDTH - 1 - SP_ULP;
  localparam logic [WIDTH-1:0] MASK1 = ~((WIDTH'(1) << UP1) - WIDTH'(1));

  logic [WIDTH-1:0] xv, xm;
  logic [WIDTH-1:0] s0_d, s1_d, s0_q, s1_q, res_d, res_q;
  logic [NSEG-1:0]  p_d, p_q, cy;
  logic             inc_q, co_d, co_q, run_c;
  logic             s1_vld_d, s1_vld_q, out_vld_d, out_vld_q;
  logic             s2_adv, s1_adv, acc;

  assign xv = x;
  assign xm = mode ? (xv & MASK1) : xv;

  assign s2_adv = ~out_vld_q | out_rdy;
  assign s1_adv = ~s1_vld_q | s2_adv;
  assign in_rdy = s1_adv & ~flush;
  assign acc    = in_vld & in_rdy;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    localparam int HI = WIDTH - 1 - k * SEG;
    localparam int LO = (HI - SEG + 1 < 0) ? 0 : HI - SEG + 1;
    localparam int SW = HI - LO + 1;
    localparam logic [SW-1:0] ONE    = SW'(1);
    localparam bit            BELOW1 = (HI < UP1);
    localparam int            OFF1   = (UP1 >= LO && UP1 <= HI) ? UP1 - LO : 0;
    // Segments entirely under the SP ULP are zero and carry-transparent.
    localparam logic [SW-1:0] STEP1  = BELOW1 ? '0 : (ONE << OFF1);
    localparam logic [SW-1:0] FILL1  = BELOW1 ? '1 : (STEP1 - ONE);

    logic [SW-1:0] xs, step, fill;
    assign xs   = xm[HI:LO];
    assign step = mode ? STEP1 : ONE;
    assign fill = mode ? FILL1 : '0;

    assign s0_d[HI:LO]  = xs;
    assign s1_d[HI:LO]  = xs + step;
    assign p_d[k]       = &(xs | fill);
    assign res_d[HI:LO] = cy[k] ? s1_q[HI:LO] : s0_q[HI:LO];
  end

  // Carry ripples from the least significant segment (highest k) toward segment 0.
  always_comb begin
    run_c = inc_q;
    cy    = '0;
    for (int k = NSEG - 1; k >= 0; k--) begin
      cy[k] = run_c;
      run_c = run_c & p_q[k];
    end
    co_d = run_c;
  end

  always_comb begin
    s1_vld_d  = s1_vld_q;
    out_vld_d = out_vld_q;
    if (s1_adv) s1_vld_d = acc;
    if (s2_adv) out_vld_d = s1_vld_q;
    if (flush) begin
      s1_vld_d  = 1'b0;
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge nclk or negedge rst_b) begin
    if (!rst_b) begin
      s1_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
      s0_q      <= '0;
      s1_q      <= '0;
      p_q       <= '0;
      inc_q     <= 1'b0;
      res_q     <= '0;
      co_q      <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      out_vld_q <= out_vld_d;
      if (acc) begin
        s0_q  <= s0_d;
        s1_q  <= s1_d;
        p_q   <= p_d;
        inc_q <= inc;
      end
      if (s2_adv && s1_vld_q) begin
        res_q <= res_d;
        co_q  <= co_d;
      end
    end
  end

  assign out_vld = out_vld_q;
  assign res     = res_q;
  assign co      = co_q;

endmodule
